// File: rtl/rc4_core_scheduler_if.sv
// rc4_core_scheduler_if: control and core-array signals of the key scheduler.
// slave = scheduler side, master = top level and core array side.
interface rc4_core_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 22
);
    logic                       start;
    logic [NUM_CORES-1:0]       core_start;
    logic [NUM_CORES*KEY_W-1:0] core_key;
    logic                       core_abort;
    logic [NUM_CORES-1:0]       core_done;
    logic [NUM_CORES-1:0]       core_found;
    logic                       busy;
    logic                       done;
    logic                       found;
    logic [KEY_W-1:0]           found_key;
    logic [3:0]                 found_core;
    logic [KEY_W:0]             keys_dispatched;

    modport slave (
        input  start, core_done, core_found,
        output core_start, core_key, core_abort,
        output busy, done, found, found_key, found_core,
        output keys_dispatched
    );

    modport master (
        output start, core_done, core_found,
        input  core_start, core_key, core_abort,
        input  busy, done, found, found_key, found_core,
        input  keys_dispatched
    );
endinterface

// File: rtl/rc4_core_scheduler.sv
// rc4_core_scheduler: hands keys KEY_MIN..KEY_MAX to parallel RC4 crack cores,
// latches the first winning key, aborts the array on a hit, reports exhaustion.
module rc4_core_scheduler #(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = 22,
    parameter logic [KEY_W-1:0] KEY_MIN   = '0,
    parameter logic [KEY_W-1:0] KEY_MAX   = '1
) (
    input logic                 clk,
    input logic                 reset,
    rc4_core_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [KEY_W-1:0] KEY_ONE = KEY_W'(1);
    localparam logic [KEY_W:0]   CNT_ONE = (KEY_W + 1)'(1);

    state_t                     state_q;
    logic [NUM_CORES-1:0]       flags_q;
    logic [NUM_CORES-1:0]       core_start_q;
    logic [NUM_CORES*KEY_W-1:0] core_key_q;
    logic                       core_abort_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       found_q;
    logic [KEY_W-1:0]           found_key_q;
    logic [3:0]                 found_core_q;
    logic [KEY_W-1:0]           cnt_q;
    logic [KEY_W:0]             kd_q;

    logic                       active;
    logic [NUM_CORES-1:0]       retire;
    logic [NUM_CORES-1:0]       hits;
    logic                       hit_any;
    logic [3:0]                 hit_idx;
    logic [KEY_W-1:0]           hit_key;
    logic                       sel_ok;
    logic [3:0]                 sel_idx;
    logic [NUM_CORES-1:0]       sel_oh;
    logic                       start_now;
    logic                       disp_en;
    logic [KEY_W-1:0]           disp_key;
    logic                       disp_last;
    logic [NUM_CORES-1:0]       flags_d;

    // Completions only count for cores that hold a key; lowest hit wins
    always_comb begin
        active  = (state_q == S_RUN) || (state_q == S_DRAIN);
        retire  = active ? (bus.core_done & flags_q) : '0;
        hits    = retire & bus.core_found;
        hit_any = |hits;
        hit_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hits[i]) hit_idx = 4'(i);
        end
        hit_key = core_key_q[int'(hit_idx)*KEY_W +: KEY_W];
    end

    // Next key goes to the lowest idle core; a start also dispatches at once
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!flags_q[i]) begin
                sel_ok    = 1'b1;
                sel_idx   = 4'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
        start_now = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE);
        disp_en   = sel_ok && (start_now || state_q == S_RUN);
        disp_key  = start_now ? KEY_MIN : cnt_q;
        disp_last = (disp_key == KEY_MAX);
        flags_d   = (flags_q & ~retire) | (disp_en ? sel_oh : '0);
    end

    // Search FSM with registered dispatch and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            flags_q      <= '0;
            core_start_q <= '0;
            core_key_q   <= '0;
            core_abort_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            found_key_q  <= '0;
            found_core_q <= '0;
            cnt_q        <= KEY_MIN;
            kd_q         <= '0;
        end else begin
            core_start_q <= '0;
            core_abort_q <= 1'b0;
            if (disp_en) begin
                core_start_q <= sel_oh;
                core_key_q[int'(sel_idx)*KEY_W +: KEY_W] <= disp_key;
                cnt_q <= disp_last ? disp_key : disp_key + KEY_ONE;
                kd_q  <= (start_now ? '0 : kd_q) + CNT_ONE;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_now) begin
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        found_q      <= 1'b0;
                        found_key_q  <= '0;
                        found_core_q <= '0;
                        flags_q      <= flags_d;
                        state_q      <= disp_last ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (hit_any) begin
                        found_key_q  <= hit_key;
                        found_core_q <= hit_idx;
                        found_q      <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        core_abort_q <= 1'b1;
                        flags_q      <= '0;
                        state_q      <= S_DONE;
                    end else begin
                        flags_q <= flags_d;
                        if (state_q == S_DRAIN) begin
                            if (flags_d == '0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end
                        end else if (disp_en && disp_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.core_start      = core_start_q;
    assign bus.core_key        = core_key_q;
    assign bus.core_abort      = core_abort_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.found           = found_q;
    assign bus.found_key       = found_key_q;
    assign bus.found_core      = found_core_q;
    assign bus.keys_dispatched = kd_q;
endmodule

// File: tb/tb_rc4_core_scheduler.sv
// tb_rc4_core_scheduler: key-order scoreboard, behavioural core array,
// table of search scenarios plus hand-written corner sequences.
module tb_rc4_core_scheduler;
    localparam int NC = 4;
    localparam int KW = 22;

    typedef struct {
        int lat;
        int hit_key;
        int exp_found;
        int exp_key;
        int exp_core;
        int exp_kd;
        int exp_cyc;
    } vec_t;

    logic clk;
    logic reset;

    rc4_core_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();

    rc4_core_scheduler #(
        .NUM_CORES(NC),
        .KEY_W    (KW),
        .KEY_MIN  (22'd0),
        .KEY_MAX  (22'd7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int chk = 0;
    int err = 0;
    int exp_q[$];
    int starts_seen = 0;
    int aborts_seen = 0;
    logic done_prev = 1'b0;
    logic cd_edge = 1'b0;

    logic    resp_en = 1'b0;
    int      resp_lat = 1;
    int      resp_hit = -1;
    logic [NC-1:0] r_act = '0;
    int      r_cnt[NC];
    int      r_key[NC];

    vec_t vecs[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] kslice(input int i);
        return bus.core_key[i*KW +: KW];
    endfunction

    // Remember whether any core_done was presented at the last edge
    always @(posedge clk) cd_edge <= |bus.core_done;

    // Scoreboard: every dispatch must carry the next expected key
    always begin
        @(negedge clk);
        if (bus.core_abort) aborts_seen++;
        for (int i = 0; i < NC; i++) begin
            if (bus.core_start[i]) begin
                starts_seen++;
                if (exp_q.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL extra_dispatch: core %0d key %0d, none expected",
                             i, kslice(i));
                end else begin
                    check("dispatch_key", kslice(i), exp_q.pop_front());
                end
            end
        end
        if (bus.done && !done_prev) check("done_latency", cd_edge, 1);
        done_prev = bus.done;
    end

    // Behavioural crack cores: fixed latency, found when key matches
    always begin
        @(negedge clk);
        if (resp_en) begin
            bus.core_done  = '0;
            bus.core_found = '0;
            if (reset || bus.core_abort) begin
                r_act = '0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (bus.core_start[i]) begin
                        r_act[i] = 1'b1;
                        r_cnt[i] = resp_lat;
                        r_key[i] = int'(kslice(i));
                    end else if (r_act[i]) begin
                        r_cnt[i]--;
                        if (r_cnt[i] == 0) begin
                            bus.core_done[i]  = 1'b1;
                            bus.core_found[i] = (resp_hit >= 0) &&
                                                (r_key[i] == resp_hit);
                            r_act[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        exp_q.delete();
        for (int k = 0; k <= 7; k++) exp_q.push_back(k);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_core_start"}, bus.core_start, 0);
        check({tag, "_core_key"}, bus.core_key, 0);
        check({tag, "_core_abort"}, bus.core_abort, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_found"}, bus.found, 0);
        check({tag, "_found_key"}, bus.found_key, 0);
        check({tag, "_found_core"}, bus.found_core, 0);
        check({tag, "_kd"}, bus.keys_dispatched, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int s0;
        int a0;
        int cyc;
        resp_lat = v.lat;
        resp_hit = v.hit_key;
        r_act    = '0;
        resp_en  = 1'b1;
        s0 = starts_seen;
        a0 = aborts_seen;
        pulse_start();
        check("vec_first_start", bus.core_start, 4'b0001);
        check("vec_first_key", kslice(0), 0);
        check("vec_restart_done", bus.done, 0);
        check("vec_restart_found", bus.found, 0);
        check("vec_busy", bus.busy, 1);
        cyc = 1;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("vec_cycles", cyc, v.exp_cyc);
        check("vec_found", bus.found, v.exp_found);
        check("vec_found_key", bus.found_key, v.exp_key);
        check("vec_found_core", bus.found_core, v.exp_core);
        check("vec_kd", bus.keys_dispatched, v.exp_kd);
        check("vec_busy_end", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("vec_aborts", aborts_seen - a0, v.exp_found);
        check("vec_starts", starts_seen - s0, v.exp_kd);
        check("vec_done_held", bus.done, 1);
        resp_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5, -1, 0, 0, 0, 8, 17};
        vecs[1] = '{5,  6, 1, 6, 2, 8, 16};
        vecs[2] = '{3,  0, 1, 0, 0, 4,  5};
        vecs[3] = '{1,  7, 1, 7, 1, 8, 10};
        vecs[4] = '{1, -1, 0, 0, 0, 8, 10};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.core_done  = '0;
        bus.core_found = '0;
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        // Cores never answer: four dispatches then the array is full
        pulse_start();
        check("a_start0", bus.core_start, 4'b0001);
        @(negedge clk);
        check("a_start1", bus.core_start, 4'b0010);
        check("a_key1", kslice(1), 1);
        @(negedge clk);
        check("a_start2", bus.core_start, 4'b0100);
        @(negedge clk);
        check("a_start3", bus.core_start, 4'b1000);
        check("a_key3", kslice(3), 3);
        @(negedge clk);
        check("a_no_start", bus.core_start, 0);
        repeat (5) @(negedge clk);
        check("a_busy", bus.busy, 1);
        check("a_kd", bus.keys_dispatched, 4);
        check("a_starts", starts_seen, 4);
        do_reset();

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Cores 1 and 3 hit together: lower index wins
        pulse_start();
        repeat (3) @(negedge clk);
        bus.core_done  = 4'b1010;
        bus.core_found = 4'b1010;
        @(negedge clk);
        bus.core_done  = '0;
        bus.core_found = '0;
        check("dual_found", bus.found, 1);
        check("dual_done", bus.done, 1);
        check("dual_core", bus.found_core, 1);
        check("dual_key", bus.found_key, 1);
        check("dual_abort", bus.core_abort, 1);
        @(negedge clk);
        check("dual_abort_off", bus.core_abort, 0);

        // Spurious done on an idle core and start during RUN are ignored
        pulse_start();
        bus.core_done  = 4'b1000;
        bus.core_found = 4'b1000;
        @(negedge clk);
        bus.core_done  = '0;
        bus.core_found = '0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("spur_start3", bus.core_start, 4'b1000);
        check("spur_key3", kslice(3), 3);
        @(negedge clk);
        check("spur_kd", bus.keys_dispatched, 4);
        check("spur_done", bus.done, 0);
        check("spur_busy", bus.busy, 1);
        do_reset();

        // Reset in the middle of a search after five dispatches
        resp_lat = 1;
        resp_hit = -1;
        r_act    = '0;
        resp_en  = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        check("mid_kd", bus.keys_dispatched, 5);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[4]);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/rc4_core_scheduler.md
Name: rc4_core_scheduler

Overview:
- Dispatches candidate secret keys to NUM_CORES parallel RC4 crack cores. Each core is a self-contained init/scramble/decrypt pipeline with its own s_memory.
- Collects per-core pass/fail results. Latches the first key that decrypts correctly and aborts all cores on a hit.
- Reports exhaustion of the key space.
- Sits between the top level (KEY/LED/HEX) and the core array. It replaces the single-core key_generator sequencing.

Parameters:
- NUM_CORES, 4, number of crack cores (1..16).
- KEY_W, 22, secret key width in bits.
- KEY_MIN, 0, first key dispatched.
- KEY_MAX, 22'h3FFFFF, last key dispatched (inclusive, KEY_MAX >= KEY_MIN).

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search from KEY_MIN.
- core_start  out  NUM_CORES  per-core one-cycle start pulse.
- core_key  out  NUM_CORES*KEY_W  per-core assigned key. Slice i = [i*KEY_W +: KEY_W].
- core_abort  out  1  one-cycle pulse to all cores: stop and return to idle.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_found  in  NUM_CORES  per-core result. Qualified by core_done: 1 means the message decrypted correctly.
- busy  out  1  search in progress.
- done  out  1  search finished. Level, held until next start or reset.
- found  out  1  valid with done: 1 means a key was found.
- found_key  out  KEY_W  winning key. Valid when done && found.
- found_core  out  4  index of the winning core.
- keys_dispatched  out  KEY_W+1  count of core_start pulses issued this search.

Behaviour:
- Reset (synchronous, active-high, any state):
  - FSM goes to IDLE.
  - All outputs are 0. core_key is 0.
  - All per-core busy flags are cleared.
  - The key counter is set to KEY_MIN.
  - Cores share the same reset, so no abort is issued.
- State IDLE:
  - On start: key counter = KEY_MIN, keys_dispatched = 0, busy = 1, go to RUN.
- State RUN:
  - Each cycle, the lowest-index core with busy flag = 0 is selected.
  - For that core: core_start[i] pulses, core_key slice i = counter, its busy flag is set, counter += 1, keys_dispatched += 1.
  - At most one dispatch per cycle.
  - core_key slice i holds its value until that core's next dispatch.
  - When the dispatched key equals KEY_MAX, go to DRAIN the next cycle with no further dispatch. The counter must not wrap.
- Completion, in any of RUN or DRAIN:
  - core_done[i] with busy flag i set clears flag i at the next edge. Core i is eligible for dispatch one cycle after its done.
  - core_done[i] while flag i is clear is ignored.
- Hit, in RUN or DRAIN:
  - Trigger: core_done[i] && core_found[i] && flag i set.
  - Next cycle: found_key = key held in slice i, found_core = i, found = 1, done = 1, busy = 0.
  - core_abort pulses for exactly 1 cycle. All busy flags clear. Go to DONE.
  - Multiple simultaneous hits: the lowest index wins.
  - A hit and a dispatch in the same cycle: the dispatch is still issued, then aborted.
- State DRAIN:
  - No dispatch.
  - When all busy flags are clear and there is no hit: done = 1, found = 0, busy = 0, go to DONE.
- State DONE:
  - Outputs are held. core_done/core_found are ignored.
  - start re-runs the search: done, found, found_key and found_core clear; go to RUN.
- start while in RUN or DRAIN is ignored.
- KEY_MIN == KEY_MAX: exactly one dispatch, then DRAIN.
- Latency:
  - First core_start is 1 cycle after the start pulse.
  - done is 1 cycle after the final core_done.

Test Plan:
- NUM_CORES=4, KEY_MIN=0, KEY_MAX=7; start; cores never respond -> core_start on cores 0,1,2,3 in consecutive cycles with keys 0,1,2,3; no further dispatch; busy=1.
- Same setup; each core returns done with found=0 after 5 cycles -> keys 0..7 each dispatched exactly once; keys_dispatched=8; done=1, found=0 one cycle after the last done.
- Core 2 holding key 6 returns done with found=1 -> next cycle done=1, found=1, found_key=6, found_core=2; core_abort high for exactly 1 cycle; no core_start afterwards.
- Cores 1 and 3 report found in the same cycle -> found_core=1 and found_key = core 1's key.
- Reset asserted mid-RUN after 5 dispatches -> next cycle all outputs 0; a subsequent start dispatches key 0 to core 0.
- Spurious core_done on an idle core, and start pulsed during RUN -> no state change; counter and keys_dispatched unaffected.
